pwm_duty_decoder: RTL and testbench

//  Measures an external PWM command (e.g. from a host controller) and converts it to a 10-bit duty

---
 rtl/pwm_duty_decoder.sv | 115 +++++++++++
 tb/tb_pwm_duty_decoder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: times a filtered external PWM and converts it to a 10-bit duty (high*1024/period)
module pwm_duty_decoder #(
  parameter int CNT_W          = 16,
  parameter int FILTER_LEN     = 4,
  parameter int MIN_PERIOD     = 64,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pwm_in,
  output logic [9:0]       o_duty,
  output logic [CNT_W-1:0] o_period,
  output logic             o_valid,
  output logic             o_error,
  output logic             o_timeout
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam logic [CNT_W-1:0] SAT  = '1;
  localparam logic [CNT_W-1:0] TO   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] MINP = CNT_W'(MIN_PERIOD);
  localparam logic [3:0]       FL   = 4'(FILTER_LEN - 1);
  state_t state, nxt;
  logic [1:0] rst_s, sync;
  logic rst, s, level, flip, rise, fall, hit, start, short_p, busy, ge;
  logic [3:0] fcnt, step;
  logic [CNT_W-1:0] high_cnt, period_cnt, idle_cnt, rem, den, nrem;
  logic [CNT_W:0] sh;
  logic [9:0] quo;
  // reset asserts immediately, releases on a clock edge
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) rst_s <= 2'b11;
    else rst_s <= {rst_s[0], 1'b0};
  assign rst   = rst_s[1];
  assign s     = sync[1];
  assign flip  = (s != level) && (fcnt == FL);
  assign rise  = flip & s;
  assign fall  = flip & ~s;
  assign hit   = !flip && (idle_cnt == TO - CNT_W'(1));
  assign sh    = {rem, 1'b0};
  assign ge    = sh >= {1'b0, den};
  assign nrem  = ge ? sh[CNT_W-1:0] - den : sh[CNT_W-1:0];
  always_comb begin
    nxt     = state;
    start   = 1'b0;
    short_p = 1'b0;
    case (state)
      IDLE:    nxt = rise ? HIGH : IDLE;
      HIGH:    nxt = fall ? LOW : HIGH;
      LOW: begin
        nxt     = rise ? HIGH : LOW;
        start   = rise && (period_cnt >= MINP);
        short_p = rise && (period_cnt < MINP);
      end
      default: nxt = IDLE;
    endcase
    if (hit) nxt = IDLE;
  end
  always_ff @(posedge i_clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge i_clk or posedge rst)
    if (rst) begin
      sync       <= '0;
      level      <= 1'b0;
      fcnt       <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      idle_cnt   <= '0;
      busy       <= 1'b0;
      step       <= '0;
      rem        <= '0;
      den        <= '0;
      quo        <= '0;
      o_duty     <= '0;
      o_period   <= '0;
      o_valid    <= 1'b0;
      o_error    <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      sync       <= {sync[0], i_pwm_in};
      level      <= flip ? s : level;
      fcnt       <= (s == level || flip) ? '0 : fcnt + 4'd1;
      period_cnt <= rise ? CNT_W'(1) : period_cnt + CNT_W'(period_cnt != SAT);
      high_cnt   <= rise ? CNT_W'(1) : high_cnt + CNT_W'(level && !fall && high_cnt != SAT);
      idle_cnt   <= flip ? '0 : idle_cnt + CNT_W'(idle_cnt != TO);
      o_valid    <= 1'b0;
      o_error    <= short_p;
      // loss of signal overrides and aborts any divide in flight
      if (hit) begin
        busy <= 1'b0;
        if (!o_timeout) begin
          o_timeout <= 1'b1;
          o_valid   <= 1'b1;
          o_duty    <= {10{level}};
          o_period  <= '0;
        end
      end else if (start) begin
        busy <= 1'b1;
        step <= 4'd10;
        rem  <= high_cnt;
        den  <= period_cnt;
        quo  <= '0;
      end else if (busy && step != 4'd0) begin
        step <= step - 4'd1;
        rem  <= nrem;
        quo  <= {quo[8:0], ge};
      end else if (busy) begin
        busy      <= 1'b0;
        o_valid   <= 1'b1;
        o_duty    <= quo;
        o_period  <= den;
        o_timeout <= 1'b0;
      end
    end
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: scoreboard bench driving PWM patterns and checking decoded duty/period/flags
module tb_pwm_duty_decoder;
  logic clk = 1'b0;
  logic rst, pwm, valid, error, tmo;
  logic [9:0] duty;
  logic [15:0] period;
  always #5 clk = ~clk;
  pwm_duty_decoder dut (
    .i_clk(clk), .i_reset(rst), .i_pwm_in(pwm),
    .o_duty(duty), .o_period(period), .o_valid(valid), .o_error(error), .o_timeout(tmo)
  );
  typedef struct {logic [9:0] duty; logic [15:0] period; logic tmo; int rcyc;} exp_t;
  typedef struct {int high; int period; int reps; logic [9:0] duty;} vec_t;
  exp_t q[$];
  exp_t pend, got;
  bit pend_ok, armed;
  int total, bad, cyc, err_seen, exp_err, valid_seen, base;
  vec_t tv[6];
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask
  // a rise closes the period in progress: expect a result or an error pulse
  task automatic rise_point();
    if (armed) begin
      if (pend_ok) q.push_back('{pend.duty, pend.period, 1'b0, cyc});
      else exp_err++;
    end
    armed = 1'b1;
  endtask
  task automatic run_period(int h, int p, logic [9:0] d);
    rise_point();
    pend.duty = d;
    pend.period = 16'(p);
    pend_ok = p >= 64;
    pwm = 1'b1;
    repeat (h) @(negedge clk);
    pwm = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (error) err_seen++;
    if (valid) begin
      valid_seen++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got duty=%0d period=%0d, want no pulse", duty, period);
      end else begin
        got = q.pop_front();
        chk("duty", 32'(duty), 32'(got.duty));
        chk("period", 32'(period), 32'(got.period));
        chk("timeout_flag", 32'(tmo), 32'(got.tmo));
        if (got.rcyc >= 0) chk("latency", 32'(cyc - got.rcyc), 32'd17);
      end
    end
  end
  initial begin
    tv[0] = '{100, 400, 3, 10'd256};
    tv[1] = '{4, 400, 2, 10'd10};
    tv[2] = '{396, 400, 2, 10'd1013};
    tv[3] = '{200, 400, 1, 10'd512};
    tv[4] = '{30, 128, 2, 10'd240};
    tv[5] = '{1000, 3000, 1, 10'd341};
    rst = 1'b1;
    pwm = 1'b0;
    armed = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty", 32'(duty), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_timeout", 32'(tmo), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    // steady PWM patterns, including the narrowest pulses the filter passes
    for (int i = 0; i < 6; i++)
      repeat (tv[i].reps) run_period(tv[i].high, tv[i].period, tv[i].duty);
    run_period(100, 400, 10'd256);
    chk("tbl_drain", 32'(q.size()), 0);
    chk("tbl_err", 32'(err_seen), 0);
    chk("tbl_last_duty", 32'(duty), 341);
    // short glitch in the low phase must not register as an edge
    rise_point();
    pend.duty = 10'd256;
    pend.period = 16'd400;
    pend_ok = 1'b1;
    pwm = 1'b1;
    repeat (100) @(negedge clk);
    pwm = 1'b0;
    repeat (100) @(negedge clk);
    pwm = 1'b1;
    repeat (2) @(negedge clk);
    pwm = 1'b0;
    repeat (198) @(negedge clk);
    run_period(100, 400, 10'd256);
    chk("glitch_err", 32'(err_seen), 0);
    chk("glitch_duty", 32'(duty), 256);
    chk("glitch_drain", 32'(q.size()), 0);
    // short periods are rejected with an error pulse each
    repeat (3) run_period(10, 40, 10'd0);
    run_period(100, 400, 10'd256);
    run_period(100, 400, 10'd256);
    chk("short_err_cnt", 32'(err_seen), 32'(exp_err));
    chk("short_err_total", 32'(exp_err), 3);
    chk("short_duty", 32'(duty), 256);
    chk("short_drain", 32'(q.size()), 0);
    // loss of signal while held high
    base = valid_seen;
    rise_point();
    pwm = 1'b1;
    q.push_back('{10'd1023, 16'd0, 1'b1, -1});
    begin
      int w = 0;
      while (!tmo && w < 50100) begin
        @(negedge clk);
        w++;
      end
    end
    chk("timeout_seen", 32'(tmo), 1);
    armed = 1'b0;
    repeat (1000) @(negedge clk);
    chk("timeout_level", 32'(tmo), 1);
    chk("timeout_duty", 32'(duty), 1023);
    chk("timeout_period", 32'(period), 0);
    chk("timeout_valids", 32'(valid_seen - base), 2);
    chk("timeout_drain", 32'(q.size()), 0);
    pwm = 1'b0;
    repeat (300) @(negedge clk);
    repeat (3) run_period(100, 400, 10'd256);
    chk("resume_timeout", 32'(tmo), 0);
    chk("resume_duty", 32'(duty), 256);
    chk("resume_drain", 32'(q.size()), 0);
    // reset five cycles into a divide discards the result
    rise_point();
    pwm = 1'b1;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    pwm = 1'b0;
    q.delete();
    armed = 1'b0;
    #1;
    chk("midrst_duty", 32'(duty), 0);
    chk("midrst_period", 32'(period), 0);
    chk("midrst_valid", 32'(valid), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = valid_seen;
    repeat (30) @(negedge clk);
    chk("midrst_novalid", 32'(valid_seen - base), 0);
    run_period(100, 400, 10'd256);
    chk("midrst_one_period", 32'(valid_seen - base), 0);
    run_period(100, 400, 10'd256);
    chk("midrst_valids", 32'(valid_seen - base), 1);
    chk("midrst_duty_after", 32'(duty), 256);
    chk("midrst_drain", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
